// File: rtl/dmem_arb_pkg.sv
// Shared types and widths for the CPU/debug DMEM arbiter.
// Read-owner encoding and the starve counter width helper live here.
package dmem_arb_pkg;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int STATS_W    = 16;
  localparam int STARVE_LIM = 4;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_CPU  = 2'd1,
    R_DBG  = 2'd2
  } rown_e;

  function automatic int cnt_w(input int lim);
    return (lim < 1) ? 1 : $clog2(lim + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_sat_counter.sv
// Saturating up-counter with enable and synchronous clear.
// Clear dominates enable; the count holds once it reaches MAX.
module dmem_arb_sat_counter #(
  parameter int          W   = 16,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != MAX))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port DMEM arbiter: CPU priority with a debug starvation guard.
// Optional stats ports/counters enabled by DMEM_ARB_STATS_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_W,
  parameter int DATA_WIDTH   = DATA_W,
  parameter int STARVE_LIMIT = STARVE_LIM
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_stall,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0]    conflict_cnt,
  output logic [STATS_W-1:0]    stall_cnt
`endif
);

  localparam int           SW   = cnt_w(STARVE_LIMIT);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

  logic          both;
  logic          force_dbg;
  logic          cpu_gnt;
  logic [SW-1:0] starve_q;
  rown_e         rown_q, rown_d;

  assign both      = cpu_req & dbg_req;
  assign force_dbg = both & (starve_q == SLIM);
  assign cpu_gnt   = cpu_req & ~force_dbg;
  assign dbg_gnt   = dbg_req & (~cpu_req | force_dbg);
  assign cpu_stall = cpu_req & ~cpu_gnt;

  always_comb begin
    mem_en    = (cpu_gnt | dbg_gnt) & ~reset;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      cpu_gnt: begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      dbg_gnt: begin
        mem_we    = dbg_we;
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
      end
      default: ;
    endcase
  end

  // Lost conflicts count up; any debug grant or idle debug resets the guard
  dmem_arb_sat_counter #(
    .W   (SW),
    .MAX (SLIM)
  ) u_starve (
    .clk   (clk),
    .clr_i (reset | dbg_gnt | ~dbg_req),
    .en_i  (both & cpu_gnt),
    .cnt_o (starve_q)
  );

  always_comb begin
    rown_d = R_IDLE;
    unique case (1'b1)
      cpu_gnt & ~cpu_we: rown_d = R_CPU;
      dbg_gnt & ~dbg_we: rown_d = R_DBG;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      rown_q <= R_IDLE;
    else
      rown_q <= rown_d;
  end

  // Reset in the return cycle drops the pending read data
  assign cpu_rvalid = (rown_q == R_CPU) & ~reset;
  assign dbg_rvalid = (rown_q == R_DBG) & ~reset;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

`ifdef DMEM_ARB_STATS_EN
  dmem_arb_sat_counter #(
    .W   (STATS_W),
    .MAX ('1)
  ) u_conf (
    .clk   (clk),
    .clr_i (reset),
    .en_i  (both),
    .cnt_o (conflict_cnt)
  );

  dmem_arb_sat_counter #(
    .W   (STATS_W),
    .MAX ('1)
  ) u_stall (
    .clk   (clk),
    .clr_i (reset),
    .en_i  (cpu_stall),
    .cnt_o (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vectors, a reference arbitration
// model checked every cycle, and literal spot checks.
module tb_dmem_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        cpu_stall, cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic        dbg_req, dbg_we;
  logic [15:0] dbg_addr, dbg_wdata;
  logic        dbg_gnt, dbg_rvalid;
  logic [15:0] dbg_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] conflict_cnt, stall_cnt;
`endif

  dmem_arbiter #(
    .ADDR_WIDTH   (16),
    .DATA_WIDTH   (16),
    .STARVE_LIMIT (LIM)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_stall    (cpu_stall),
    .cpu_rvalid   (cpu_rvalid),
    .cpu_rdata    (cpu_rdata),
    .dbg_req      (dbg_req),
    .dbg_we       (dbg_we),
    .dbg_addr     (dbg_addr),
    .dbg_wdata    (dbg_wdata),
    .dbg_gnt      (dbg_gnt),
    .dbg_rvalid   (dbg_rvalid),
    .dbg_rdata    (dbg_rdata),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .conflict_cnt (conflict_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // DMEM environment: registered read, write at the edge
  logic [15:0] mem [0:65535];
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'hA5A5;
    mem_rdata = '0;
  end
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
  endtask

  // Reference model
  logic [15:0] refmem [int];
  int          m_starve = 0;
  int          m_pend   = 0;
  logic [15:0] m_pdata  = '0;
  int          m_conf   = 0;
  int          m_stall  = 0;
  bit          mon_en   = 0;

  function automatic logic [15:0] refread(input logic [15:0] a);
    if (refmem.exists(int'(a))) return refmem[int'(a)];
    return a ^ 16'hA5A5;
  endfunction

  function automatic void mgrant(output bit ec, output bit ed);
    if (cpu_req && dbg_req) begin
      ec = (m_starve < LIM);
      ed = !ec;
    end else begin
      ec = cpu_req;
      ed = dbg_req;
    end
  endfunction

  always @(posedge clk) begin
    bit ec, ed;
    if (reset) begin
      m_starve = 0;
      m_pend   = 0;
      m_conf   = 0;
      m_stall  = 0;
    end else begin
      mgrant(ec, ed);
      if (cpu_req && dbg_req && m_conf < 65535) m_conf++;
      if (cpu_req && !ec && m_stall < 65535) m_stall++;
      m_pend = 0;
      if (ec) begin
        if (cpu_we) refmem[int'(cpu_addr)] = cpu_wdata;
        else begin m_pend = 1; m_pdata = refread(cpu_addr); end
      end else if (ed) begin
        if (dbg_we) refmem[int'(dbg_addr)] = dbg_wdata;
        else begin m_pend = 2; m_pdata = refread(dbg_addr); end
      end
      if (cpu_req && dbg_req && ec)
        m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
      else
        m_starve = 0;
    end
  end

  always @(negedge clk) begin
    bit ec, ed;
    if (mon_en) begin
      mgrant(ec, ed);
      chk("m_cpu_stall", 32'(cpu_stall), 32'(cpu_req && !ec));
      chk("m_dbg_gnt", 32'(dbg_gnt), 32'(ed));
      chk("m_mem_en", 32'(mem_en), 32'((ec || ed) && !reset));
      if (mem_en) begin
        chk("m_mem_we", 32'(mem_we), 32'(ec ? cpu_we : dbg_we));
        chk("m_mem_addr", 32'(mem_addr), 32'(ec ? cpu_addr : dbg_addr));
        if (ec ? cpu_we : dbg_we)
          chk("m_mem_wdata", 32'(mem_wdata),
              32'(ec ? cpu_wdata : dbg_wdata));
      end
      chk("m_cpu_rvalid", 32'(cpu_rvalid), 32'(m_pend == 1 && !reset));
      chk("m_dbg_rvalid", 32'(dbg_rvalid), 32'(m_pend == 2 && !reset));
      chk("m_cpu_rdata", 32'(cpu_rdata),
          32'((m_pend == 1 && !reset) ? m_pdata : 16'h0));
      chk("m_dbg_rdata", 32'(dbg_rdata),
          32'((m_pend == 2 && !reset) ? m_pdata : 16'h0));
`ifdef DMEM_ARB_STATS_EN
      chk("m_conflict_cnt", 32'(conflict_cnt), 32'(m_conf));
      chk("m_stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
    end
  end

  task automatic setc(input bit r, input bit we,
                      input logic [15:0] a, input logic [15:0] d);
    cpu_req = r; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic setd(input bit r, input bit we,
                      input logic [15:0] a, input logic [15:0] d);
    dbg_req = r; dbg_we = we; dbg_addr = a; dbg_wdata = d;
  endtask

  task automatic idle();
    setc(0, 0, 16'h0, 16'h0);
    setd(0, 0, 16'h0, 16'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick();
    tick();
    mon_en = 1;
    #1;
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
    chk("rst_dbg_rvalid", 32'(dbg_rvalid), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    tick();
    reset = 1'b0;

    // 1: CPU store then load
    setc(1, 1, 16'h0010, 16'hBEEF);
    #1;
    chk("t1_mem_we", 32'(mem_we), 1);
    chk("t1_stall", 32'(cpu_stall), 0);
    tick();
    setc(1, 0, 16'h0010, 16'h0);
    #1;
    chk("t1_ld_stall", 32'(cpu_stall), 0);
    tick();
    idle();
    #1;
    chk("t1_rvalid", 32'(cpu_rvalid), 1);
    chk("t1_rdata", 32'(cpu_rdata), 32'h0000BEEF);
    tick();

    // 2: five conflict cycles, debug forced on the fifth
    setc(1, 0, 16'h0020, 16'h0);
    setd(1, 0, 16'h0030, 16'h0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_stall", 32'(cpu_stall), 32'(i == 4));
      chk("t2_dgnt", 32'(dbg_gnt), 32'(i == 4));
      tick();
    end
    idle();
    #1;
    chk("t2_dbg_rvalid", 32'(dbg_rvalid), 1);
    chk("t2_dbg_rdata", 32'(dbg_rdata), 32'h0000A595);
    chk("t2_cpu_rvalid", 32'(cpu_rvalid), 0);
    tick();

    // 3: alternating reads
    setc(1, 0, 16'h0001, 16'h0);
    tick();
    idle();
    setd(1, 0, 16'h0002, 16'h0);
    #1;
    chk("t3_c_rvalid", 32'(cpu_rvalid), 1);
    chk("t3_c_rdata", 32'(cpu_rdata), 32'h0000A5A4);
    chk("t3_d_quiet", 32'(dbg_rvalid), 0);
    tick();
    idle();
    setc(1, 0, 16'h0001, 16'h0);
    #1;
    chk("t3_d_rvalid", 32'(dbg_rvalid), 1);
    chk("t3_d_rdata", 32'(dbg_rdata), 32'h0000A5A7);
    chk("t3_c_quiet", 32'(cpu_rvalid), 0);
    tick();
    idle();
    #1;
    chk("t3_c2_rvalid", 32'(cpu_rvalid), 1);
    chk("t3_c2_rdata", 32'(cpu_rdata), 32'h0000A5A4);
    tick();

    // 4: reset right after a granted CPU read, starve guard reset
    setc(1, 0, 16'h0040, 16'h0);
    setd(1, 0, 16'h0050, 16'h0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("t4_rst_rvalid", 32'(cpu_rvalid), 0);
    chk("t4_rst_mem_en", 32'(mem_en), 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (i == 0) chk("t4_no_rvalid", 32'(cpu_rvalid), 0);
      chk("t4_stall", 32'(cpu_stall), 32'(i == 4));
      tick();
    end
    idle();
    tick();

    // 5: debug write alone, CPU reads it back
    setd(1, 1, 16'h0003, 16'h1234);
    #1;
    chk("t5_dgnt", 32'(dbg_gnt), 1);
    tick();
    idle();
    #1;
    chk("t5_no_rvalid", 32'(dbg_rvalid), 0);
    tick();
    setc(1, 0, 16'h0003, 16'h0);
    tick();
    idle();
    #1;
    chk("t5_rdata", 32'(cpu_rdata), 32'h00001234);
    tick();

    // 6: stats after a fresh reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    setc(1, 0, 16'h0060, 16'h0);
    setd(1, 0, 16'h0070, 16'h0);
    for (int i = 0; i < 5; i++) tick();
    idle();
    #1;
`ifdef DMEM_ARB_STATS_EN
    chk("t6_conflict", 32'(conflict_cnt), 5);
    chk("t6_stall", 32'(stall_cnt), 1);
`endif
    chk("t6_dbg_rvalid", 32'(dbg_rvalid), 1);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
